// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage.
// Issues word requests from the fetch PC, buffers returned words with their
// PCs in an in-order FIFO, presents them to decode with valid/ready, and
// flushes/discards in-flight responses on redirect.
// Outstanding requests plus buffered words never exceed FIFO_DEPTH, so the
// buffer cannot overflow.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned redirect halts
// fetch and raises misaligned until an aligned redirect or reset).
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instruccion,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic        misaligned
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  // Architectural state
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      rsp_pc_q, rsp_pc_d;
  logic [31:0]      trap_pc_q, trap_pc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic             halted_q, halted_d;
  logic [31:0]      buf_instr_q [FIFO_DEPTH];
  logic [31:0]      buf_instr_d [FIFO_DEPTH];
  logic [31:0]      buf_pc_q [FIFO_DEPTH];
  logic [31:0]      buf_pc_d [FIFO_DEPTH];

  // Combinational helpers
  logic [31:0]  target_pc_s;
  logic         target_misaligned_s;
  logic [CNT_W:0] occupancy_s;
  logic         grant_s;
  logic         rsp_fire_s;
  logic         pop_s;
  logic         push_s;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign target_pc_s         = redirect_pc;
  assign target_misaligned_s = (redirect_pc[1:0] != 2'b00);
  assign misaligned          = halted_q;
`else
  logic unused_redirect_lsb_s;
  assign target_pc_s           = {redirect_pc[31:2], 2'b00};
  assign target_misaligned_s   = 1'b0;
  assign misaligned            = 1'b0;
  assign unused_redirect_lsb_s = ^redirect_pc[1:0];
`endif

  // Outputs taken from registered state
  assign imem_addr   = fetch_pc_q;
  assign instr_valid = (count_q != {CNT_W{1'b0}});
  assign instruccion = buf_instr_q[rd_ptr_q];
  assign pc_plus4    = pc_out + 32'd4;

  // While halted the trapping target is reported on pc_out
  always_comb begin
    pc_out = buf_pc_q[rd_ptr_q];
    if (halted_q) begin
      pc_out = trap_pc_q;
    end else begin
      pc_out = buf_pc_q[rd_ptr_q];
    end
  end

  // Request credit: buffered words plus in-flight requests stay within depth
  always_comb begin
    occupancy_s = {1'b0, count_q} + {1'b0, outstanding_q};
    imem_req    = 1'b0;
    if (!reset && !redirect && !halted_q && (occupancy_s < DEPTH_C)) begin
      imem_req = 1'b1;
    end else begin
      imem_req = 1'b0;
    end
    grant_s    = imem_req && imem_gnt;
    rsp_fire_s = imem_rvalid && (outstanding_q != {CNT_W{1'b0}});
    pop_s      = instr_valid && instr_ready;
  end

  // Next-state: redirect overrides grant, push and pop
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    trap_pc_d     = trap_pc_q;
    count_d       = count_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    halted_d      = halted_q;
    buf_instr_d   = buf_instr_q;
    buf_pc_d      = buf_pc_q;
    push_s        = 1'b0;

    if (redirect) begin
      fetch_pc_d = target_pc_s;
      rsp_pc_d   = target_pc_s;
      count_d    = {CNT_W{1'b0}};
      rd_ptr_d   = {PTR_W{1'b0}};
      wr_ptr_d   = {PTR_W{1'b0}};
      // Every response still to arrive belongs to the old stream
      if (rsp_fire_s) begin
        outstanding_d = outstanding_q - CNT_ONE;
        drop_d        = outstanding_q - CNT_ONE;
      end else begin
        outstanding_d = outstanding_q;
        drop_d        = outstanding_q;
      end
      halted_d = target_misaligned_s;
      if (target_misaligned_s) begin
        trap_pc_d = target_pc_s;
      end else begin
        trap_pc_d = trap_pc_q;
      end
    end else begin
      if (grant_s) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end else begin
        fetch_pc_d = fetch_pc_q;
      end

      if (grant_s && !rsp_fire_s) begin
        outstanding_d = outstanding_q + CNT_ONE;
      end else if (!grant_s && rsp_fire_s) begin
        outstanding_d = outstanding_q - CNT_ONE;
      end else begin
        outstanding_d = outstanding_q;
      end

      if (rsp_fire_s) begin
        if (drop_q != {CNT_W{1'b0}}) begin
          drop_d = drop_q - CNT_ONE;
        end else begin
          push_s   = 1'b1;
          rsp_pc_d = rsp_pc_q + 32'd4;
        end
      end else begin
        drop_d = drop_q;
      end

      if (push_s) begin
        buf_instr_d[wr_ptr_q] = imem_rdata;
        buf_pc_d[wr_ptr_q]    = rsp_pc_q;
        wr_ptr_d              = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end

      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end

      if (push_s && !pop_s) begin
        count_d = count_q + CNT_ONE;
      end else if (!push_s && pop_s) begin
        count_d = count_q - CNT_ONE;
      end else begin
        count_d = count_q;
      end
    end
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      trap_pc_q     <= RESET_PC;
      count_q       <= {CNT_W{1'b0}};
      outstanding_q <= {CNT_W{1'b0}};
      drop_q        <= {CNT_W{1'b0}};
      rd_ptr_q      <= {PTR_W{1'b0}};
      wr_ptr_q      <= {PTR_W{1'b0}};
      halted_q      <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        buf_instr_q[i] <= 32'h0000_0000;
        buf_pc_q[i]    <= 32'h0000_0000;
      end
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      trap_pc_q     <= trap_pc_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      halted_q      <= halted_d;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        buf_instr_q[i] <= buf_instr_d[i];
        buf_pc_q[i]    <= buf_pc_d[i];
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit (RESET_PC = 0, FIFO_DEPTH = 2).
// Memory responses are driven by hand, one cycle after each grant.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruccion;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        misaligned;

  int pass_cnt;
  int fail_cnt;
  int total_cnt;

  localparam logic [31:0] W0 = 32'h0050_0093;
  localparam logic [31:0] W1 = 32'h00A0_0113;
  localparam logic [31:0] W2 = 32'h0020_81B3;
  localparam logic [31:0] D0 = 32'h1111_1111;
  localparam logic [31:0] D1 = 32'h2222_2222;
  localparam logic [31:0] T0 = 32'hCAFE_0100;
  localparam logic [31:0] T1 = 32'hCAFE_0104;
  localparam logic [31:0] U0 = 32'h0200_0001;
  localparam logic [31:0] V0 = 32'h0400_0001;
  localparam logic [31:0] X0 = 32'h0200_0002;
  localparam logic [31:0] Y0 = 32'hFFFF_0001;
  localparam logic [31:0] STALE = 32'hDEAD_BEEF;

  fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .FIFO_DEPTH(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instruccion(instruccion),
    .pc_out     (pc_out),
    .pc_plus4   (pc_plus4),
    .misaligned (misaligned)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt = total_cnt + 1;
    assert (obs === exp) pass_cnt = pass_cnt + 1;
    else begin
      fail_cnt = fail_cnt + 1;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total_cnt = total_cnt + 1;
    assert (obs === exp) pass_cnt = pass_cnt + 1;
    else begin
      fail_cnt = fail_cnt + 1;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Directed sequence
  initial begin
    pass_cnt = 0; fail_cnt = 0; total_cnt = 0;
    reset = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    redirect = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b0;
    tick(); tick();
    chk1("rst_req", imem_req, 1'b0);
    chk1("rst_valid", instr_valid, 1'b0);
    chk1("rst_misaligned", misaligned, 1'b0);
    chk("rst_addr", imem_addr, 32'h0);

    // Streaming
    reset = 1'b0; imem_gnt = 1'b1; instr_ready = 1'b1; #1;
    chk1("s0_req", imem_req, 1'b1); chk("s0_addr", imem_addr, 32'h0);
    tick();
    imem_rvalid = 1'b1; imem_rdata = W0; #1;
    chk1("s1_req", imem_req, 1'b1); chk("s1_addr", imem_addr, 32'h4);
    chk1("s1_valid", instr_valid, 1'b0);
    tick();
    imem_rdata = W1; #1;
    chk1("s2_valid", instr_valid, 1'b1); chk("s2_pc", pc_out, 32'h0);
    chk("s2_instr", instruccion, W0); chk("s2_pc4", pc_plus4, 32'h4);
    chk1("s2_req_credit", imem_req, 1'b0);
    tick();
    imem_rvalid = 1'b0; #1;
    chk1("s3_valid", instr_valid, 1'b1); chk("s3_pc", pc_out, 32'h4);
    chk("s3_instr", instruccion, W1); chk("s3_pc4", pc_plus4, 32'h8);
    chk1("s3_req", imem_req, 1'b1); chk("s3_addr", imem_addr, 32'h8);
    tick();
    imem_rvalid = 1'b1; imem_rdata = W2; imem_gnt = 1'b0; #1;
    chk1("s4_valid", instr_valid, 1'b0); chk("s4_addr", imem_addr, 32'hC);
    tick();
    imem_rvalid = 1'b0; #1;
    chk1("s5_valid", instr_valid, 1'b1); chk("s5_pc", pc_out, 32'h8);
    chk("s5_instr", instruccion, W2); chk("s5_pc4", pc_plus4, 32'hC);
    tick();

    // Reset before backpressure
    instr_ready = 1'b0; reset = 1'b1; imem_gnt = 1'b1; #1;
    chk1("r_req", imem_req, 1'b0); chk1("r_valid", instr_valid, 1'b0);
    tick();

    // Backpressure
    reset = 1'b0; #1;
    chk1("b0_req", imem_req, 1'b1); chk("b0_addr", imem_addr, 32'h0);
    tick();
    imem_rvalid = 1'b1; imem_rdata = D0; #1;
    chk1("b1_req", imem_req, 1'b1); chk("b1_addr", imem_addr, 32'h4);
    tick();
    imem_rdata = D1; #1;
    chk1("b2_req", imem_req, 1'b0); chk1("b2_valid", instr_valid, 1'b1);
    chk("b2_pc", pc_out, 32'h0);
    tick();
    imem_rvalid = 1'b0; #1;
    chk1("b3_req", imem_req, 1'b0); chk("b3_instr", instruccion, D0);
    tick();
    instr_ready = 1'b1; #1;
    chk1("b4_req", imem_req, 1'b0); chk("b4_pc", pc_out, 32'h0);
    tick();

    // Memory stall with request pending at 0x8
    instr_ready = 1'b0; imem_gnt = 1'b0; #1;
    chk1("b5_req", imem_req, 1'b1); chk("b5_addr", imem_addr, 32'h8);
    chk("b5_pc", pc_out, 32'h4); chk("b5_instr", instruccion, D1);
    tick(); #1;
    chk1("b6_req", imem_req, 1'b1); chk("b6_addr", imem_addr, 32'h8);
    tick(); #1;
    chk1("b7_req", imem_req, 1'b1); chk("b7_addr", imem_addr, 32'h8);
    chk1("b7_valid", instr_valid, 1'b1); chk("b7_pc", pc_out, 32'h4);
    tick();
    imem_gnt = 1'b1; #1;
    chk1("b8_req", imem_req, 1'b1); chk("b8_addr", imem_addr, 32'h8);
    tick();
    instr_ready = 1'b1; #1;
    chk1("b9_req", imem_req, 1'b0); chk("b9_addr", imem_addr, 32'hC);
    tick(); #1;
    chk1("b10_valid", instr_valid, 1'b0); chk1("b10_req", imem_req, 1'b1);
    chk("b10_addr", imem_addr, 32'hC);
    tick();

    // Redirect with two requests in flight
    redirect = 1'b1; redirect_pc = 32'h100; #1;
    chk1("rd_req", imem_req, 1'b0);
    tick();
    redirect = 1'b0; imem_rvalid = 1'b1; imem_rdata = STALE; #1;
    chk1("rd0_req", imem_req, 1'b0); chk("rd0_addr", imem_addr, 32'h100);
    chk1("rd0_valid", instr_valid, 1'b0);
    tick();
    imem_rdata = STALE; #1;
    chk1("rd1_valid", instr_valid, 1'b0); chk1("rd1_req", imem_req, 1'b1);
    chk("rd1_addr", imem_addr, 32'h100);
    tick();
    imem_rdata = T0; imem_gnt = 1'b0; #1;
    chk1("rd2_valid", instr_valid, 1'b0); chk("rd2_addr", imem_addr, 32'h104);
    tick();
    imem_rvalid = 1'b0; imem_gnt = 1'b1; instr_ready = 1'b1; #1;
    chk1("rd3_valid", instr_valid, 1'b1); chk("rd3_pc", pc_out, 32'h100);
    chk("rd3_instr", instruccion, T0); chk("rd3_pc4", pc_plus4, 32'h104);
    tick(); #1;
    chk1("rd4_valid", instr_valid, 1'b0); chk("rd4_addr", imem_addr, 32'h108);
    tick();
    imem_rvalid = 1'b1; imem_rdata = T1; imem_gnt = 1'b0; #1;
    chk1("rd5_req", imem_req, 1'b0);
    tick();

    // Collision: redirect, response and pop in one cycle
    redirect = 1'b1; redirect_pc = 32'h200; imem_rdata = STALE; #1;
    chk1("col_valid", instr_valid, 1'b1); chk("col_pc", pc_out, 32'h104);
    chk("col_instr", instruccion, T1); chk1("col_req", imem_req, 1'b0);
    tick();
    redirect = 1'b0; imem_rdata = STALE; #1;
    chk1("col1_valid", instr_valid, 1'b0); chk1("col1_req", imem_req, 1'b1);
    chk("col1_addr", imem_addr, 32'h200);
    tick();
    imem_rvalid = 1'b0; imem_gnt = 1'b1; #1;
    chk1("spur_valid", instr_valid, 1'b0); chk("spur_addr", imem_addr, 32'h200);
    tick();
    imem_rvalid = 1'b1; imem_rdata = U0; imem_gnt = 1'b0; #1;
    chk1("col3_valid", instr_valid, 1'b0);
    tick();
    imem_rvalid = 1'b0; instr_ready = 1'b0; #1;
    chk1("col4_valid", instr_valid, 1'b1); chk("col4_pc", pc_out, 32'h200);
    chk("col4_instr", instruccion, U0);

    // Back-to-back redirects
    redirect = 1'b1; redirect_pc = 32'h300;
    tick();
    redirect_pc = 32'h400; #1;
    chk1("bb_valid", instr_valid, 1'b0); chk1("bb_req", imem_req, 1'b0);
    tick();
    redirect = 1'b0; imem_gnt = 1'b1; #1;
    chk1("bb1_req", imem_req, 1'b1); chk("bb1_addr", imem_addr, 32'h400);
    tick();
    imem_rvalid = 1'b1; imem_rdata = V0; imem_gnt = 1'b0; #1;
    chk("bb2_addr", imem_addr, 32'h404);
    tick();
    imem_rvalid = 1'b0; #1;
    chk1("bb3_valid", instr_valid, 1'b1); chk("bb3_pc", pc_out, 32'h400);
    chk("bb3_instr", instruccion, V0);

    // Misaligned redirect
    redirect = 1'b1; redirect_pc = 32'h102;
    tick();
    redirect = 1'b0; #1;
    chk1("mis_valid", instr_valid, 1'b0);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk1("mis_flag", misaligned, 1'b1); chk1("mis_req", imem_req, 1'b0);
    chk("mis_pc", pc_out, 32'h102);
`else
    chk1("mis_flag", misaligned, 1'b0); chk1("mis_req", imem_req, 1'b1);
    chk("mis_addr", imem_addr, 32'h100);
`endif
    tick(); #1;
`ifdef FETCH_MISALIGN_TRAP_EN
    chk1("mis1_flag", misaligned, 1'b1); chk1("mis1_req", imem_req, 1'b0);
`else
    chk1("mis1_req", imem_req, 1'b1);
`endif
    redirect = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect = 1'b0; imem_gnt = 1'b1; #1;
    chk1("al_flag", misaligned, 1'b0); chk1("al_req", imem_req, 1'b1);
    chk("al_addr", imem_addr, 32'h200); chk1("al_valid", instr_valid, 1'b0);
    tick();
    imem_rvalid = 1'b1; imem_rdata = X0; imem_gnt = 1'b0; #1;
    chk("al1_addr", imem_addr, 32'h204);
    tick();
    imem_rvalid = 1'b0; imem_gnt = 1'b1; #1;
    chk1("al2_valid", instr_valid, 1'b1); chk("al2_pc", pc_out, 32'h200);
    chk("al2_instr", instruccion, X0);
    tick();

    // Reset mid-stream with a request in flight
    imem_gnt = 1'b0; reset = 1'b1; #1;
    chk1("rm_req", imem_req, 1'b0);
    tick();
    reset = 1'b0; imem_rvalid = 1'b1; imem_rdata = STALE; #1;
    chk1("rm1_valid", instr_valid, 1'b0); chk1("rm1_mis", misaligned, 1'b0);
    chk1("rm1_req", imem_req, 1'b1); chk("rm1_addr", imem_addr, 32'h0);
    tick();
    imem_rvalid = 1'b0; #1;
    chk1("rm2_valid", instr_valid, 1'b0);

    // PC wrap at 2^32
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0; imem_gnt = 1'b1; #1;
    chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    imem_rvalid = 1'b1; imem_rdata = Y0; #1;
    chk1("wr1_req", imem_req, 1'b1); chk("wr1_addr", imem_addr, 32'h0);
    tick();
    imem_rvalid = 1'b0; imem_gnt = 1'b0; #1;
    chk1("wr2_valid", instr_valid, 1'b1); chk("wr2_pc", pc_out, 32'hFFFF_FFFC);
    chk("wr2_instr", instruccion, Y0); chk("wr2_pc4", pc_plus4, 32'h0);
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
